muldiv_seq: RTL

- Iterative sequencer for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the execute-stage ALU.
- On an M-extension opcode in EX it holds the pipeline, runs a 32-step shift-add multiply or restoring divide, and presents result_m with flagM, which the ALU selects for ALUResult.
- Owns the datapath registers and the stall handshake for the multi-cycle op.

---
 rtl/muldiv_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//                REM/REMU). Holds the pipeline while a 32-step shift-add
//                multiply or restoring divide runs, then pulses flagM with
//                the result for the execute-stage ALU to select.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32   // must equal XLEN
) (
    input  logic            clk,
    input  logic            rst,       // asynchronous, active-low
    input  logic [4:0]      alu_opE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            flushE,
    output logic            stall_m,
    output logic            flagM,
    output logic [XLEN-1:0] result_m,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;     // product, or remainder:quotient
    logic [XLEN-1:0]     opb_q, opb_d;     // multiplicand / divisor magnitude
    logic [4:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                stall_w;

    // ------------------------------------------------------------------
    // Decode of the EX-stage opcode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic            is_m_w, is_div_w, is_rem_w, is_sdiv_w;
    logic            sgn_a_en_w, sgn_b_en_w;
    logic            sign_a_w, sign_b_w;
    logic [XLEN-1:0] mag_a_w, mag_b_w;
    logic            div_zero_w, div_ovf_w, fast_w;
    logic [XLEN-1:0] fast_res_w;

    assign is_m_w     = (alu_opE >= OP_MUL) && (alu_opE <= OP_REMU);
    assign is_div_w   = (alu_opE >= OP_DIV) && (alu_opE <= OP_REMU);
    assign is_rem_w   = (alu_opE == OP_REM) || (alu_opE == OP_REMU);
    assign is_sdiv_w  = (alu_opE == OP_DIV) || (alu_opE == OP_REM);
    assign sgn_a_en_w = (alu_opE == OP_MUL) || (alu_opE == OP_MULH) ||
                        (alu_opE == OP_MULHSU) || is_sdiv_w;
    assign sgn_b_en_w = (alu_opE == OP_MUL) || (alu_opE == OP_MULH) || is_sdiv_w;

    assign sign_a_w = sgn_a_en_w & SrcAE[XLEN-1];
    assign sign_b_w = sgn_b_en_w & SrcBE[XLEN-1];
    assign mag_a_w  = sign_a_w ? -SrcAE : SrcAE;
    assign mag_b_w  = sign_b_w ? -SrcBE : SrcBE;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    // Overflow quotient equals the dividend (MIN_NEG); overflow remainder is 0.
    assign div_zero_w = is_div_w && (SrcBE == '0);
    assign div_ovf_w  = is_sdiv_w && (SrcAE == MIN_NEG) && (SrcBE == '1);
    assign fast_w     = div_zero_w || div_ovf_w;
    assign fast_res_w = is_rem_w ? (div_zero_w ? SrcAE : '0)
                                 : (div_zero_w ? '1    : SrcAE);

    // ------------------------------------------------------------------
    // One iteration step of each algorithm, computed from the registers
    // ------------------------------------------------------------------
    logic              is_div_q_w;
    logic [XLEN:0]     mul_sum_w;
    logic [2*XLEN-1:0] mul_next_w;
    logic [XLEN:0]     div_shift_w;
    logic [XLEN+1:0]   div_diff_w;
    logic              div_ge_w;
    logic [2*XLEN-1:0] div_next_w;

    assign is_div_q_w = (op_q >= OP_DIV);

    // Add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole product right keeping the carry.
    assign mul_sum_w  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                        (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign mul_next_w = {mul_sum_w, acc_q[XLEN-1:1]};

    // Restoring divide: shift remainder:quotient left, trial-subtract.
    assign div_shift_w = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff_w  = {1'b0, div_shift_w} - {2'b00, opb_q};
    assign div_ge_w    = (div_diff_w[XLEN+1:XLEN] == 2'b00);
    assign div_next_w  = div_ge_w ? {div_diff_w[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1}
                                  : {div_shift_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign correction and result selection used in FIX
    // ------------------------------------------------------------------
    logic              neg_w;
    logic [2*XLEN-1:0] prod_fix_w;
    logic [XLEN-1:0]   quo_fix_w, rem_fix_w;
    logic [XLEN-1:0]   fix_res_w;

    assign neg_w      = sign_a_q ^ sign_b_q;
    assign prod_fix_w = neg_w    ? -acc_q : acc_q;
    assign quo_fix_w  = neg_w    ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix_w  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    // Pick the architectural result for the latched opcode
    always_comb begin
        fix_res_w = rem_fix_w;
        case (op_q)
            OP_MUL:                        fix_res_w = prod_fix_w[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_w = prod_fix_w[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res_w = quo_fix_w;
            default:                       fix_res_w = rem_fix_w;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state, datapath updates and stall request
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;
        stall_w  = 1'b0;

        if (flushE) begin
            // A killed EX instruction abandons the op; result is kept.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_m_w) begin
                        stall_w  = 1'b1;
                        op_d     = alu_opE;
                        sign_a_d = sign_a_w;
                        sign_b_d = sign_b_w;
                        opb_d    = mag_b_w;
                        acc_d    = {{XLEN{1'b0}}, mag_a_w};
                        cnt_d    = '0;
                        if (fast_w) begin
                            result_d = fast_res_w;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    stall_w = 1'b1;
                    acc_d   = is_div_q_w ? div_next_w : mul_next_w;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    stall_w  = 1'b1;
                    result_d = fix_res_w;
                    state_d  = S_DONE;
                end
                default: begin    // S_DONE: pipeline advances this edge
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
        end
    end

    // Stall is suppressed while reset is asserted
    assign stall_m  = stall_w & rst;
    assign flagM    = (state_q == S_DONE);
    assign result_m = result_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
